// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: decodes a UART byte stream into register writes/reads and returns read data over UART
//   clk, rstb               clock (rising edge), asynchronous active-low reset
//   rx_valid, rx_data       one-cycle received-byte strobe and its value
//   tx_busy                 UART transmitter busy
//   tx_wr_en, tx_wr_data    one-cycle transmit request and the byte to send (read response)
//   reg_wr_en, reg_rd_en    one-cycle register write / read strobes
//   reg_addr, reg_wr_data   register address and write data, held between commands
//   reg_rd_data             register read data, valid one cycle after reg_rd_en
//   drop_err                sticky: a byte arrived while a command was executing
//   busy                    high whenever not idle
// Commands: 0x00 addr data = write, 0x01 addr = read.
module uart_reg_bridge #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_wr_en,
    output logic [7:0] tx_wr_data,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] reg_rd_data,
    output logic       drop_err,
    output logic       busy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, WRITE, READ, READ_WAIT, TX_WAIT, TX_SEND, TX_HOLD
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] tmo_cnt;
    logic          op_rd;
    logic          collect;
    logic          tmo;

    assign collect = state == GET_ADDR || state == GET_DATA;
    assign tmo = tmo_cnt == CW'(TIMEOUT_CYCLES - 1);

    assign reg_wr_en = state == WRITE;
    assign reg_rd_en = state == READ;
    assign tx_wr_en  = state == TX_SEND;
    assign busy      = state != IDLE;

    // A byte arriving in the expiry cycle is taken before the timeout is considered.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = (rx_valid && rx_data[7:1] == 7'd0) ? GET_ADDR : IDLE;
            GET_ADDR:  state_nx = rx_valid ? (op_rd ? READ : GET_DATA) : (tmo ? IDLE : GET_ADDR);
            GET_DATA:  state_nx = rx_valid ? WRITE : (tmo ? IDLE : GET_DATA);
            READ:      state_nx = READ_WAIT;
            READ_WAIT: state_nx = TX_WAIT;
            TX_WAIT:   state_nx = tx_busy ? TX_WAIT : TX_SEND;
            TX_SEND:   state_nx = TX_HOLD;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            op_rd       <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            tx_wr_data  <= '0;
            drop_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            tmo_cnt     <= (collect && !rx_valid && !tmo) ? tmo_cnt + CW'(1) : '0;
            if (state == IDLE && rx_valid) op_rd <= rx_data[0];
            if (state == GET_ADDR && rx_valid) reg_addr <= rx_data;
            if (state == GET_DATA && rx_valid) reg_wr_data <= rx_data;
            if (state == READ_WAIT) tx_wr_data <= reg_rd_data;
            // Bytes during command execution are discarded and flagged.
            if (rx_valid && state != IDLE && !collect) drop_err <= 1'b1;
        end
    end
endmodule
